// File: rtl/soe_to_si_12_hrx1_pkg.sv
// soe_to_si_12_hrx1_pkg: shared constants, sizing helpers and state encoding for the series-to-parallel reassembler
package soe_to_si_12_hrx1_pkg;
  localparam int NUM_ELEMS = 12;
  typedef enum logic {WAIT_START = 1'b0, COLLECT = 1'b1} state_t;
  function automatic int num_beats(int lanes);
    return NUM_ELEMS / lanes;
  endfunction
  function automatic int series_width(int lanes);
    return num_beats(lanes) > 1 ? $clog2(num_beats(lanes)) : 1;
  endfunction
endpackage

// File: rtl/soe_to_si_12_hrx1_if.sv
// soe_to_si_12_hrx1_if: beat input bus carrying lanes of one series
interface soe_to_si_12_hrx1_if #(parameter int LANES = 4, parameter int IN_WIDTH = 10);
  logic enable;
  logic inReady;
  logic newInSeriesStart;
  logic [LANES*IN_WIDTH-1:0] inVec;
  modport master(output enable, inReady, newInSeriesStart, inVec);
  modport slave(input enable, inReady, newInSeriesStart, inVec);
endinterface

// File: rtl/soe_to_si_12_hrx1_beat_counter.sv
// soe_beat_counter: framing state and beat index, with accept/last/restart/error strobes
module soe_beat_counter
  import soe_to_si_12_hrx1_pkg::*;
#(
  parameter int LANES = 4,
  localparam int NB = num_beats(LANES),
  localparam int SW = series_width(LANES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          in_ready,
  input  logic          start,
  output logic          accept,
  output logic          last,
  output logic          restart,
  output logic          error,
  output logic          busy,
  output logic [SW-1:0] out_series
);
  state_t state;
  always_comb begin
    accept  = !reset && enable && in_ready;
    restart = accept && start && state == COLLECT;
    error   = accept && (start ? state == COLLECT : state == WAIT_START);
    last    = accept && (start ? NB == 1 : state == COLLECT && out_series == SW'(NB - 1));
    busy    = state == COLLECT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_START;
      out_series <= '0;
    end else if (accept && (start || state == COLLECT)) begin
      state      <= last ? WAIT_START : COLLECT;
      out_series <= last ? '0 : start ? SW'(1) : out_series + 1'b1;
    end
  end
endmodule

// File: rtl/soe_to_si_12_hrx1.sv
// soe_to_si_12_hrx1: reassembles 12 signed elements from series beats behind a shadow buffer
module soe_to_si_12_hrx1
  import soe_to_si_12_hrx1_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int LANES = 4,
  localparam int SW = series_width(LANES)
) (
  input  logic                       clk,
  input  logic                       reset,
  soe_to_si_12_hrx1_if.slave         bus,
  output logic [SW-1:0]              outSeries,
  output logic signed [IN_WIDTH-1:0] O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, O10, O11,
  output logic                       O0toO11OutReady,
  output logic                       seriesError,
  output logic                       busy
);
  logic accept, last, restart, error, store;
  logic [SW-1:0] idx;
  logic signed [IN_WIDTH-1:0] shadow [NUM_ELEMS];
  logic signed [IN_WIDTH-1:0] merged [NUM_ELEMS];
  logic signed [IN_WIDTH-1:0] o [NUM_ELEMS];
  soe_beat_counter #(.LANES(LANES)) u_cnt (
    .clk(clk), .reset(reset), .enable(bus.enable), .in_ready(bus.inReady),
    .start(bus.newInSeriesStart), .accept(accept), .last(last), .restart(restart),
    .error(error), .busy(busy), .out_series(outSeries)
  );
  // the incoming beat is overlaid on the shadow so a publish sees the final beat on the same edge
  always_comb begin
    store = (accept && !error) || restart;
    idx = bus.newInSeriesStart ? '0 : outSeries;
    for (int e = 0; e < NUM_ELEMS; e++)
      merged[e] = (e / LANES == int'(idx)) ? bus.inVec[(e % LANES)*IN_WIDTH +: IN_WIDTH] : shadow[e];
  end
  always_ff @(posedge clk) begin
    if (store) shadow <= merged;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o               <= '{default: '0};
      O0toO11OutReady <= 1'b0;
      seriesError     <= 1'b0;
    end else begin
      O0toO11OutReady <= last;
      seriesError     <= error;
      if (last) o <= merged;
    end
  end
  assign {O0, O1, O2, O3, O4, O5} = {o[0], o[1], o[2], o[3], o[4], o[5]};
  assign {O6, O7, O8, O9, O10, O11} = {o[6], o[7], o[8], o[9], o[10], o[11]};
endmodule

// File: tb/tb_soe_to_si_12_hrx1.sv
// tb_soe_to_si_12_hrx1: directed checks of the reassembler at LANES=4, 12 and 1
module tb_soe_to_si_12_hrx1;
  logic clk = 0, reset;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;

  soe_to_si_12_hrx1_if #(.LANES(4), .IN_WIDTH(10)) b4();
  soe_to_si_12_hrx1_if #(.LANES(12), .IN_WIDTH(10)) b12();
  soe_to_si_12_hrx1_if #(.LANES(1), .IN_WIDTH(10)) b1();
  logic signed [9:0] o4 [12], o12 [12], o1 [12];
  logic [1:0] s4;
  logic [0:0] s12;
  logic [3:0] s1;
  logic r4, r12, r1, e4, e12, e1, y4, y12, y1;

  soe_to_si_12_hrx1 #(.IN_WIDTH(10), .LANES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .outSeries(s4),
    .O0(o4[0]), .O1(o4[1]), .O2(o4[2]), .O3(o4[3]), .O4(o4[4]), .O5(o4[5]),
    .O6(o4[6]), .O7(o4[7]), .O8(o4[8]), .O9(o4[9]), .O10(o4[10]), .O11(o4[11]),
    .O0toO11OutReady(r4), .seriesError(e4), .busy(y4));
  soe_to_si_12_hrx1 #(.IN_WIDTH(10), .LANES(12)) dut12 (
    .clk(clk), .reset(reset), .bus(b12), .outSeries(s12),
    .O0(o12[0]), .O1(o12[1]), .O2(o12[2]), .O3(o12[3]), .O4(o12[4]), .O5(o12[5]),
    .O6(o12[6]), .O7(o12[7]), .O8(o12[8]), .O9(o12[9]), .O10(o12[10]), .O11(o12[11]),
    .O0toO11OutReady(r12), .seriesError(e12), .busy(y12));
  soe_to_si_12_hrx1 #(.IN_WIDTH(10), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .outSeries(s1),
    .O0(o1[0]), .O1(o1[1]), .O2(o1[2]), .O3(o1[3]), .O4(o1[4]), .O5(o1[5]),
    .O6(o1[6]), .O7(o1[7]), .O8(o1[8]), .O9(o1[9]), .O10(o1[10]), .O11(o1[11]),
    .O0toO11OutReady(r1), .seriesError(e1), .busy(y1));

  int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, -9, 10, 11, -512};
  int exp2 [12] = '{-1, -2, -3, -4, 100, 200, 300, 400, 511, -512, 0, 7};
  int exp3 [12] = '{21, 22, 23, 24, -25, -26, -27, -28, 29, 30, 31, 32};
  int zero [12] = '{default: 0};
  int x12 [12] = '{-100, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 500};
  int y12v [12] = '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, -1};
  int v1 [12];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_o(input string tag, input logic signed [9:0] got [12], input int exp [12]);
    for (int i = 0; i < 12; i++) check($sformatf("%s_O%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    b4.inReady = 0; b4.newInSeriesStart = 0; b4.enable = 1;
    repeat (n) tick();
  endtask

  task automatic beat4(input bit en, input bit s, input int a, b, c, d);
    b4.enable = en; b4.inReady = 1; b4.newInSeriesStart = s;
    b4.inVec = {10'(d), 10'(c), 10'(b), 10'(a)};
    tick();
    b4.inReady = 0; b4.newInSeriesStart = 0; b4.enable = 1;
  endtask

  task automatic series4(input int v [12]);
    beat4(1, 1, v[0], v[1], v[2], v[3]);
    beat4(1, 0, v[4], v[5], v[6], v[7]);
    beat4(1, 0, v[8], v[9], v[10], v[11]);
  endtask

  task automatic set12(input int v [12]);
    for (int i = 0; i < 12; i++) b12.inVec[i*10 +: 10] = 10'(v[i]);
  endtask

  initial begin
    reset = 1;
    b4.enable = 0; b4.inReady = 0; b4.newInSeriesStart = 0; b4.inVec = '0;
    b12.enable = 0; b12.inReady = 0; b12.newInSeriesStart = 0; b12.inVec = '0;
    b1.enable = 0; b1.inReady = 0; b1.newInSeriesStart = 0; b1.inVec = '0;
    repeat (2) tick();
    check_o("rst", o4, zero);
    check("rst_ready", r4, 0);
    check("rst_err", e4, 0);
    check("rst_series", s4, 0);
    check("rst_busy", y4, 0);
    check("rst_ready12", r12, 0);
    check("rst_series1", s1, 0);
    reset = 0;
    idle(1);
    // normal series
    beat4(1, 1, 1, 2, 3, 4);
    check("n_busy0", y4, 1);
    check("n_series0", s4, 1);
    beat4(1, 0, 5, 6, 7, 8);
    check("n_series1", s4, 2);
    check("n_ready_early", r4, 0);
    beat4(1, 0, -9, 10, 11, -512);
    check("n_ready", r4, 1);
    check("n_busy2", y4, 0);
    check("n_series2", s4, 0);
    check_o("n", o4, exp1);
    idle(1);
    check("n_ready_pulse", r4, 0);
    // gaps and stalls
    beat4(1, 1, exp2[0], exp2[1], exp2[2], exp2[3]);
    idle(3);
    check("g_series_hold", s4, 1);
    check("g_o_hold", o4[0], 1);
    beat4(0, 0, 99, 99, 99, 99);
    check("g_noen_series", s4, 1);
    check("g_noen_err", e4, 0);
    beat4(1, 0, exp2[4], exp2[5], exp2[6], exp2[7]);
    idle(3);
    check("g_o_hold2", o4[11], -512);
    check("g_ready_gap", r4, 0);
    beat4(1, 0, exp2[8], exp2[9], exp2[10], exp2[11]);
    check("g_ready", r4, 1);
    check_o("g", o4, exp2);
    // early restart
    beat4(1, 1, 77, 77, 77, 77);
    beat4(1, 0, 66, 66, 66, 66);
    beat4(1, 1, exp3[0], exp3[1], exp3[2], exp3[3]);
    check("r_err", e4, 1);
    check("r_series", s4, 1);
    check("r_busy", y4, 1);
    check("r_ready", r4, 0);
    idle(1);
    check("r_err_pulse", e4, 0);
    check_o("r_hold", o4, exp2);
    beat4(1, 0, exp3[4], exp3[5], exp3[6], exp3[7]);
    beat4(1, 0, exp3[8], exp3[9], exp3[10], exp3[11]);
    check("r_pub", r4, 1);
    check_o("r", o4, exp3);
    // missing start
    beat4(1, 0, 5, 5, 5, 5);
    check("m_err", e4, 1);
    check("m_series", s4, 0);
    check("m_busy", y4, 0);
    check("m_ready", r4, 0);
    idle(1);
    check("m_err_pulse", e4, 0);
    check("m_o_hold", o4[4], -25);
    // reset mid-series, with a beat presented on the reset edge
    beat4(1, 1, 9, 9, 9, 9);
    beat4(1, 0, 8, 8, 8, 8);
    reset = 1;
    beat4(1, 0, 7, 7, 7, 7);
    check_o("x", o4, zero);
    check("x_series", s4, 0);
    check("x_busy", y4, 0);
    check("x_err", e4, 0);
    check("x_ready", r4, 0);
    reset = 0;
    series4(exp1);
    check("x_pub", r4, 1);
    check_o("x_after", o4, exp1);
    idle(1);
    // LANES=12: every start beat publishes, back to back
    b12.enable = 1; b12.inReady = 1; b12.newInSeriesStart = 1;
    set12(x12);
    tick();
    check("w_ready0", r12, 1);
    check("w_series", s12, 0);
    check("w_busy", y12, 0);
    check_o("w0", o12, x12);
    set12(y12v);
    tick();
    check("w_ready1", r12, 1);
    check_o("w1", o12, y12v);
    b12.newInSeriesStart = 0;
    set12(x12);
    tick();
    check("w_err", e12, 1);
    check("w_ready2", r12, 0);
    check("w_hold", o12[0], 12);
    b12.inReady = 0;
    // LANES=1: twelve beats, counter wraps
    for (int k = 0; k < 12; k++) v1[k] = k * 45 - 250;
    b1.enable = 1;
    for (int k = 0; k < 12; k++) begin
      b1.inReady = 1; b1.newInSeriesStart = (k == 0); b1.inVec = 10'(v1[k]);
      tick();
      check($sformatf("s_series%0d", k), s1, (k + 1) % 12);
      check($sformatf("s_ready%0d", k), r1, k == 11);
    end
    b1.inReady = 0;
    check_o("s", o1, v1);
    tick();
    check("s_ready_pulse", r1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
